// File: rtl/video_pkg.sv
// ---------------------------------------------------------------------------
// video_pkg
// Shared definitions for the video output stage:
//   - meas_state_e : states of the frame-geometry measurement machine
//   - R/G/B_SLOT   : channel slot numbers inside the packed {B,G,R} word
//   - chan_lsb()   : LSB position of a channel slot for a given channel width
// ---------------------------------------------------------------------------
package video_pkg;

    typedef enum logic [1:0] {
        WAIT_VB = 2'd0,
        SYNCED  = 2'd1,
        RUN     = 2'd2
    } meas_state_e;

    // Packed colour word is {B,G,R} with R in the least significant slot.
    localparam int R_SLOT = 0;
    localparam int G_SLOT = 1;
    localparam int B_SLOT = 2;

    // Bit offset of a channel: R at 0, G at IN_W, B at 2*IN_W.
    function automatic int chan_lsb(input int slot, input int in_w);
        return slot * in_w;
    endfunction

endpackage

// File: rtl/video_frame_meter.sv
// ---------------------------------------------------------------------------
// video_frame_meter
// Measures active frame geometry from the raw data-enable and vblank inputs.
// Everything, including the edge detectors, advances only on ce_i.
// Ports:
//   clk_i, reset_ni        : clock, synchronous active-low reset
//   ce_i                   : pixel enable
//   de_i, vblank_i         : active-area flag and vertical blanking
//   frame_width_o          : active pixels per line of the last complete frame
//   frame_height_o         : active lines of the last complete frame
//   frame_count_o          : completed frames, wraps
//   meas_valid_o           : set once a full frame has been measured
// ---------------------------------------------------------------------------
module video_frame_meter
    import video_pkg::*;
#(
    parameter int MEAS_W = 12
) (
    input  logic              clk_i,
    input  logic              reset_ni,
    input  logic              ce_i,
    input  logic              de_i,
    input  logic              vblank_i,
    output logic [MEAS_W-1:0] frame_width_o,
    output logic [MEAS_W-1:0] frame_height_o,
    output logic [MEAS_W-1:0] frame_count_o,
    output logic              meas_valid_o
);

    localparam logic [MEAS_W-1:0] ZERO    = {MEAS_W{1'b0}};
    localparam logic [MEAS_W-1:0] ONE     = {{(MEAS_W-1){1'b0}}, 1'b1};
    localparam logic [MEAS_W-1:0] CNT_MAX = {MEAS_W{1'b1}};

    meas_state_e       state_q, state_d;
    logic [MEAS_W-1:0] pix_q, pix_d;
    logic [MEAS_W-1:0] line_w_q, line_w_d;
    logic [MEAS_W-1:0] line_cnt_q, line_cnt_d;
    logic [MEAS_W-1:0] width_q, width_d;
    logic [MEAS_W-1:0] height_q, height_d;
    logic [MEAS_W-1:0] count_q, count_d;
    logic              valid_q, valid_d;
    logic              prev_de_q, prev_de_d;
    logic              prev_vb_q, prev_vb_d;

    logic              de_fall_s;
    logic              vb_rise_s;
    logic [MEAS_W-1:0] pix_step_s;
    logic [MEAS_W-1:0] line_w_step_s;
    logic [MEAS_W-1:0] line_cnt_step_s;

    function automatic logic [MEAS_W-1:0] sat_inc(input logic [MEAS_W-1:0] v);
        return (v == CNT_MAX) ? v : v + ONE;
    endfunction

    assign de_fall_s = prev_de_q & ~de_i;
    assign vb_rise_s = ~prev_vb_q & vblank_i;

    // State register plus all measurement registers.
    always_ff @(posedge clk_i) begin
        if (!reset_ni) begin
            state_q    <= WAIT_VB;
            pix_q      <= ZERO;
            line_w_q   <= ZERO;
            line_cnt_q <= ZERO;
            width_q    <= ZERO;
            height_q   <= ZERO;
            count_q    <= ZERO;
            valid_q    <= 1'b0;
            prev_de_q  <= 1'b0;
            prev_vb_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pix_q      <= pix_d;
            line_w_q   <= line_w_d;
            line_cnt_q <= line_cnt_d;
            width_q    <= width_d;
            height_q   <= height_d;
            count_q    <= count_d;
            valid_q    <= valid_d;
            prev_de_q  <= prev_de_d;
            prev_vb_q  <= prev_vb_d;
        end
    end

    // Next-state logic: each stage is left on a vblank rising edge.
    always_comb begin
        state_d = state_q;
        if (ce_i) begin
            case (state_q)
                WAIT_VB: begin
                    if (vb_rise_s) begin
                        state_d = SYNCED;
                    end else begin
                        state_d = WAIT_VB;
                    end
                end
                SYNCED: begin
                    if (vb_rise_s) begin
                        state_d = RUN;
                    end else begin
                        state_d = SYNCED;
                    end
                end
                RUN:     state_d = RUN;
                default: state_d = WAIT_VB;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Counter datapath. The line step is computed first so that a line
    // ending on the same strobe as a vblank rise is part of the frame.
    always_comb begin
        pix_d           = pix_q;
        line_w_d        = line_w_q;
        line_cnt_d      = line_cnt_q;
        width_d         = width_q;
        height_d        = height_q;
        count_d         = count_q;
        valid_d         = valid_q;
        prev_de_d       = prev_de_q;
        prev_vb_d       = prev_vb_q;
        pix_step_s      = pix_q;
        line_w_step_s   = line_w_q;
        line_cnt_step_s = line_cnt_q;
        if (ce_i) begin
            prev_de_d = de_i;
            prev_vb_d = vblank_i;
            if (de_fall_s) begin
                line_w_step_s   = pix_q;
                pix_step_s      = ZERO;
                line_cnt_step_s = sat_inc(line_cnt_q);
            end else if (de_i) begin
                pix_step_s = sat_inc(pix_q);
            end else begin
                pix_step_s = pix_q;
            end
            case (state_q)
                WAIT_VB: begin
                    if (vb_rise_s) begin
                        pix_d      = ZERO;
                        line_w_d   = ZERO;
                        line_cnt_d = ZERO;
                    end else begin
                        pix_d = pix_q;
                    end
                end
                SYNCED, RUN: begin
                    if (vb_rise_s) begin
                        width_d    = line_w_step_s;
                        height_d   = line_cnt_step_s;
                        count_d    = count_q + ONE;
                        valid_d    = 1'b1;
                        line_w_d   = line_w_step_s;
                        line_cnt_d = ZERO;
                        pix_d      = ZERO;
                    end else begin
                        pix_d      = pix_step_s;
                        line_w_d   = line_w_step_s;
                        line_cnt_d = line_cnt_step_s;
                    end
                end
                default: begin
                    pix_d      = ZERO;
                    line_cnt_d = ZERO;
                end
            endcase
        end else begin
            pix_d = pix_q;
        end
    end

    assign frame_width_o  = width_q;
    assign frame_height_o = height_q;
    assign frame_count_o  = count_q;
    assign meas_valid_o   = valid_q;

endmodule

// File: rtl/video_out_expander.sv
// ---------------------------------------------------------------------------
// video_out_expander
// Two-stage video output pipeline (advanced on ce_pix) that widens each
// colour channel by MSB-first bit replication, blanks colour outside the
// active area, applies sync polarity, and measures frame geometry.
// Ports:
//   clk_sys, reset                 : clock, synchronous active-low reset
//   ce_pix                         : pixel enable
//   rgb_i                          : packed {B,G,R}, IN_W bits each
//   hsync_i, vsync_i               : active-high syncs
//   hblank_i, vblank_i             : active-high blanking
//   vga_r, vga_g, vga_b            : expanded colour, OUT_W bits each
//   vga_hs, vga_vs, vga_de         : output syncs and data enable
//   frame_width/height/count       : measured geometry, frame counter
//   meas_valid                     : geometry valid flag
// ---------------------------------------------------------------------------
module video_out_expander
    import video_pkg::*;
#(
    parameter int IN_W        = 3,
    parameter int OUT_W       = 8,
    parameter int MEAS_W      = 12,
    parameter bit HS_ACT_LOW  = 1'b1,
    parameter bit VS_ACT_LOW  = 1'b1,
    parameter bit BLANK_BLACK = 1'b1
) (
    input  logic                clk_sys,
    input  logic                reset,
    input  logic                ce_pix,
    input  logic [3*IN_W-1:0]   rgb_i,
    input  logic                hsync_i,
    input  logic                vsync_i,
    input  logic                hblank_i,
    input  logic                vblank_i,
    output logic [OUT_W-1:0]    vga_r,
    output logic [OUT_W-1:0]    vga_g,
    output logic [OUT_W-1:0]    vga_b,
    output logic                vga_hs,
    output logic                vga_vs,
    output logic                vga_de,
    output logic [MEAS_W-1:0]   frame_width,
    output logic [MEAS_W-1:0]   frame_height,
    output logic [MEAS_W-1:0]   frame_count,
    output logic                meas_valid
);

    localparam logic [OUT_W-1:0] COL_ZERO = {OUT_W{1'b0}};

    // Stage 1: raw input capture.
    logic [3*IN_W-1:0] rgb_s1_q;
    logic              hs_s1_q, vs_s1_q, hb_s1_q, vb_s1_q;

    // Stage 2: output registers.
    logic [OUT_W-1:0]  r_q, g_q, b_q;
    logic [OUT_W-1:0]  r_d, g_d, b_d;
    logic              hs_q, vs_q, de_q;
    logic              hs_d, vs_d, de_d;

    logic [2:0][OUT_W-1:0] exp_s;
    logic                  blank_s;

    // Stage 1 register: captures the core outputs on each pixel strobe.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            rgb_s1_q <= {(3*IN_W){1'b0}};
            hs_s1_q  <= 1'b0;
            vs_s1_q  <= 1'b0;
            hb_s1_q  <= 1'b0;
            vb_s1_q  <= 1'b0;
        end else if (ce_pix) begin
            rgb_s1_q <= rgb_i;
            hs_s1_q  <= hsync_i;
            vs_s1_q  <= vsync_i;
            hb_s1_q  <= hblank_i;
            vb_s1_q  <= vblank_i;
        end
    end

    // Output bit OUT_W-1-k copies input bit IN_W-1-(k mod IN_W); when
    // IN_W >= OUT_W this reduces to keeping the top OUT_W bits.
    for (genvar c = 0; c < 3; c++) begin : g_chan
        for (genvar k = 0; k < OUT_W; k++) begin : g_bit
            localparam int SRC = chan_lsb(c, IN_W) + IN_W - 1 - (k % IN_W);
            assign exp_s[c][OUT_W-1-k] = rgb_s1_q[SRC];
        end
    end

    assign blank_s = BLANK_BLACK & (hb_s1_q | vb_s1_q);

    // Stage 2 next values: blanked colour, polarity-adjusted syncs, enable.
    always_comb begin
        r_d  = COL_ZERO;
        g_d  = COL_ZERO;
        b_d  = COL_ZERO;
        if (blank_s) begin
            r_d = COL_ZERO;
            g_d = COL_ZERO;
            b_d = COL_ZERO;
        end else begin
            r_d = exp_s[R_SLOT];
            g_d = exp_s[G_SLOT];
            b_d = exp_s[B_SLOT];
        end
        hs_d = hs_s1_q ^ HS_ACT_LOW;
        vs_d = vs_s1_q ^ VS_ACT_LOW;
        de_d = ~(hb_s1_q | vb_s1_q);
    end

    // Stage 2 register: resets syncs to their inactive output level.
    always_ff @(posedge clk_sys) begin
        if (!reset) begin
            r_q  <= COL_ZERO;
            g_q  <= COL_ZERO;
            b_q  <= COL_ZERO;
            hs_q <= HS_ACT_LOW;
            vs_q <= VS_ACT_LOW;
            de_q <= 1'b0;
        end else if (ce_pix) begin
            r_q  <= r_d;
            g_q  <= g_d;
            b_q  <= b_d;
            hs_q <= hs_d;
            vs_q <= vs_d;
            de_q <= de_d;
        end
    end

    assign vga_r  = r_q;
    assign vga_g  = g_q;
    assign vga_b  = b_q;
    assign vga_hs = hs_q;
    assign vga_vs = vs_q;
    assign vga_de = de_q;

    video_frame_meter #(
        .MEAS_W (MEAS_W)
    ) u_meter (
        .clk_i          (clk_sys),
        .reset_ni       (reset),
        .ce_i           (ce_pix),
        .de_i           (~(hblank_i | vblank_i)),
        .vblank_i       (vblank_i),
        .frame_width_o  (frame_width),
        .frame_height_o (frame_height),
        .frame_count_o  (frame_count),
        .meas_valid_o   (meas_valid)
    );

endmodule

// File: tb/tb_video_out_expander.sv
module tb_video_out_expander;

    logic        clk_sys = 1'b0;
    logic        reset;
    logic        ce_pix;
    logic [8:0]  rgb_i;
    logic        hsync_i, vsync_i, hblank_i, vblank_i;

    // Default-parameter instance.
    logic [7:0]  a_r, a_g, a_b;
    logic        a_hs, a_vs, a_de, a_mv;
    logic [11:0] a_fw, a_fh, a_fc;

    // HS_ACT_LOW=0, MEAS_W=4 instance.
    logic [7:0]  b_r, b_g, b_b;
    logic        b_hs, b_vs, b_de, b_mv;
    logic [3:0]  b_fw, b_fh, b_fc;

    int passes = 0;
    int total  = 0;

    always #5 clk_sys = ~clk_sys;

    video_out_expander dut (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .rgb_i(rgb_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .vga_r(a_r), .vga_g(a_g), .vga_b(a_b), .vga_hs(a_hs), .vga_vs(a_vs), .vga_de(a_de),
        .frame_width(a_fw), .frame_height(a_fh), .frame_count(a_fc), .meas_valid(a_mv)
    );

    video_out_expander #(.HS_ACT_LOW(1'b0), .MEAS_W(4)) dut_b (
        .clk_sys(clk_sys), .reset(reset), .ce_pix(ce_pix), .rgb_i(rgb_i),
        .hsync_i(hsync_i), .vsync_i(vsync_i), .hblank_i(hblank_i), .vblank_i(vblank_i),
        .vga_r(b_r), .vga_g(b_g), .vga_b(b_b), .vga_hs(b_hs), .vga_vs(b_vs), .vga_de(b_de),
        .frame_width(b_fw), .frame_height(b_fh), .frame_count(b_fc), .meas_valid(b_mv)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d (0x%0h) expected %0d (0x%0h)", tag, obs, obs, exp, exp);
    endtask

    // One pixel strobe, followed by `gap` idle clocks.
    task automatic strobe(input int gap);
        ce_pix = 1'b1;
        @(posedge clk_sys);
        #1;
        ce_pix = 1'b0;
        repeat (gap) begin
            @(posedge clk_sys);
            #1;
        end
    endtask

    task automatic active_lines(input int w, input int n, input int hb, input int gap);
        vblank_i = 1'b0;
        for (int l = 0; l < n; l++) begin
            hblank_i = 1'b0;
            for (int p = 0; p < w; p++) strobe(gap);
            hblank_i = 1'b1;
            for (int p = 0; p < hb; p++) strobe(gap);
        end
    endtask

    task automatic vblank_strobes(input int n, input int gap);
        hblank_i = 1'b0;
        vblank_i = 1'b1;
        for (int p = 0; p < n; p++) strobe(gap);
    endtask

    task automatic pulse_reset();
        reset = 1'b0;
        @(posedge clk_sys);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b0; ce_pix = 1'b0; rgb_i = 9'd0;
        hsync_i = 1'b0; vsync_i = 1'b0; hblank_i = 1'b0; vblank_i = 1'b0;
        repeat (3) @(posedge clk_sys);
        #1;
        // Reset state
        check("rst_r",  32'(a_r),  32'h0);
        check("rst_de", 32'(a_de), 32'h0);
        check("rst_hs", 32'(a_hs), 32'h1);
        check("rst_vs", 32'(a_vs), 32'h1);
        check("rst_b_hs", 32'(b_hs), 32'h0);
        check("rst_fw", 32'(a_fw), 32'h0);
        check("rst_fc", 32'(a_fc), 32'h0);
        check("rst_mv", 32'(a_mv), 32'h0);
        reset = 1'b1;
        @(posedge clk_sys);
        #1;

        // Expansion and two-strobe latency
        rgb_i = 9'b101_011_110;
        strobe(1);
        check("lat1_r", 32'(a_r), 32'h0);
        strobe(1);
        check("exp_r", 32'(a_r), 32'hDB);
        check("exp_g", 32'(a_g), 32'h6D);
        check("exp_b", 32'(a_b), 32'hB6);
        check("exp_de", 32'(a_de), 32'h1);
        check("exp_hs", 32'(a_hs), 32'h1);
        check("exp_b_hs", 32'(b_hs), 32'h0);

        // Freeze while ce_pix is low
        rgb_i = 9'd0; hblank_i = 1'b1;
        repeat (5) @(posedge clk_sys);
        #1;
        check("hold_r", 32'(a_r), 32'hDB);
        check("hold_de", 32'(a_de), 32'h1);

        // Blanking and sync polarity
        rgb_i = 9'b101_011_110; hsync_i = 1'b1; hblank_i = 1'b1;
        strobe(1);
        strobe(1);
        check("blk_r", 32'(a_r), 32'h0);
        check("blk_g", 32'(a_g), 32'h0);
        check("blk_b", 32'(a_b), 32'h0);
        check("blk_de", 32'(a_de), 32'h0);
        check("blk_hs", 32'(a_hs), 32'h0);
        check("blk_b_hs", 32'(b_hs), 32'h1);
        check("blk_vs", 32'(a_vs), 32'h1);
        hsync_i = 1'b0; hblank_i = 1'b0;

        // Geometry: 256 x 240 active
        vblank_strobes(2, 0);
        check("g1_mv", 32'(a_mv), 32'h0);
        check("g1_fc", 32'(a_fc), 32'h0);
        active_lines(256, 240, 2, 0);
        vblank_strobes(1, 0);
        check("g2_fw", 32'(a_fw), 32'd256);
        check("g2_fh", 32'(a_fh), 32'd240);
        check("g2_fc", 32'(a_fc), 32'd1);
        check("g2_mv", 32'(a_mv), 32'h1);
        check("g2_b_fw_sat", 32'(b_fw), 32'd15);
        check("g2_b_fh_sat", 32'(b_fh), 32'd15);
        vblank_strobes(3, 0);
        active_lines(8, 2, 2, 0);
        vblank_strobes(1, 0);
        check("g3_fc", 32'(a_fc), 32'd2);
        check("g3_fw", 32'(a_fw), 32'd8);
        check("g3_fh", 32'(a_fh), 32'd2);

        // Saturation and wrap, ce_pix every 2nd clock
        vblank_i = 1'b0;
        pulse_reset();
        check("w0_fc", 32'(a_fc), 32'd0);
        for (int f = 1; f <= 17; f++) begin
            active_lines(20, 2, 2, 1);
            vblank_strobes(2, 1);
            if (f == 16) check("w16_b_fc", 32'(b_fc), 32'd15);
        end
        check("w_b_fw", 32'(b_fw), 32'd15);
        check("w_b_fh", 32'(b_fh), 32'd2);
        check("w_b_fc", 32'(b_fc), 32'd0);
        check("w_b_mv", 32'(b_mv), 32'h1);
        check("w_fw", 32'(a_fw), 32'd20);
        check("w_fc", 32'(a_fc), 32'd16);

        // Vblank rises on the strobe that ends the last active line
        active_lines(5, 2, 2, 1);
        hblank_i = 1'b0;
        for (int p = 0; p < 5; p++) strobe(1);
        vblank_strobes(1, 1);
        check("sim_fh", 32'(a_fh), 32'd3);
        check("sim_fw", 32'(a_fw), 32'd5);
        check("sim_fc", 32'(a_fc), 32'd17);
        check("sim_b_fc", 32'(b_fc), 32'd1);

        // Reset during line 100
        vblank_strobes(2, 0);
        active_lines(4, 99, 1, 0);
        hblank_i = 1'b0; vblank_i = 1'b0;
        strobe(0);
        strobe(0);
        pulse_reset();
        check("mr_r",  32'(a_r),  32'h0);
        check("mr_de", 32'(a_de), 32'h0);
        check("mr_hs", 32'(a_hs), 32'h1);
        check("mr_fw", 32'(a_fw), 32'h0);
        check("mr_fh", 32'(a_fh), 32'h0);
        check("mr_fc", 32'(a_fc), 32'h0);
        check("mr_mv", 32'(a_mv), 32'h0);
        strobe(0);
        strobe(0);
        hblank_i = 1'b1;
        strobe(0);
        vblank_strobes(1, 0);
        check("mr1_mv", 32'(a_mv), 32'h0);
        vblank_strobes(2, 0);
        active_lines(4, 3, 1, 0);
        vblank_strobes(1, 0);
        check("mr2_mv", 32'(a_mv), 32'h1);
        check("mr2_fw", 32'(a_fw), 32'd4);
        check("mr2_fh", 32'(a_fh), 32'd3);
        check("mr2_fc", 32'(a_fc), 32'd1);

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule

// File: doc/video_out_expander.md
# video_out_expander

Parametrised video output stage between a core's native RGB/sync outputs and the simulation or display harness. It expands packed per-channel colour of any width to display width by MSB-first bit replication, applies blanking and configurable sync polarity through a fixed two-stage pixel-enable pipeline, and measures the active frame geometry. The measured geometry and frame count let the harness size its texture and pace its display without per-core constants.

## Interface
- IN_W, 3: input bits per colour channel.
- OUT_W, 8: output bits per colour channel.
- MEAS_W, 12: width of the geometry and frame counters.
- HS_ACT_LOW, 1: 1 means vga_hs is active-low at the output.
- VS_ACT_LOW, 1: 1 means vga_vs is active-low at the output.
- BLANK_BLACK, 1: 1 forces colour to zero outside the active area.

- clk_sys  in  1  single system clock; all logic is on its rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- ce_pix  in  1  pixel enable; one clk_sys cycle per pixel.
- rgb_i  in  3*IN_W  packed {B,G,R}, with R in the LSBs.
- hsync_i, vsync_i  in  1 each  active-high syncs from the core.
- hblank_i, vblank_i  in  1 each  active-high blanking.
- vga_r, vga_g, vga_b  out  OUT_W each  expanded colour.
- vga_hs, vga_vs  out  1 each  polarity-adjusted syncs.
- vga_de  out  1  data enable, equal to !(hblank|vblank) at this pipeline stage.
- frame_width  out  MEAS_W  active pixels per line in the last complete frame.
- frame_height  out  MEAS_W  active lines in the last complete frame.
- frame_count  out  MEAS_W  completed frames; wraps modulo 2^MEAS_W.
- meas_valid  out  1  set once the first full frame has been measured.

## Operation
- Expansion: out bit OUT_W-1-k = in bit IN_W-1-(k mod IN_W), for k = 0..OUT_W-1.
  - For IN_W=3, OUT_W=8 the result is {c,c,c[2:1]}.
  - If IN_W ≥ OUT_W, the output is the top OUT_W input bits (truncation).
- Blanking: when BLANK_BLACK=1 and the delayed hblank or vblank is 1, all colour outputs are 0. Syncs are never gated.
- Polarity: vga_hs = hsync XOR HS_ACT_LOW. vga_vs follows the same rule with VS_ACT_LOW.
- Measurement state machine, advanced only on ce_pix:
  - States: WAIT_VB → SYNCED → RUN.
  - WAIT_VB waits for the first vblank rising edge (vblank_i=1 while the previous sample was 0). It then clears the counters and moves to SYNCED.
  - SYNCED behaves like RUN, except that the first vblank rising edge after entry latches the outputs, sets meas_valid, and moves to RUN.
  - RUN: pix_cnt increments on active pixels and saturates at 2^MEAS_W-1.
  - RUN, on a de falling edge (active pixel followed by inactive): line_w ← pix_cnt, pix_cnt ← 0, line_cnt increments (saturating).
  - RUN, on a vblank rising edge: frame_width ← line_w, frame_height ← line_cnt, frame_count++, then line_cnt ← 0 and pix_cnt ← 0.
- If a de falling edge and a vblank rising edge occur on the same ce_pix, the line is counted first. frame_height includes that line.
- A frame with zero active lines latches frame_height=0 and frame_width=last line_w. meas_valid stays 1.

## Timing
- Video path latency: exactly 2 ce_pix strobes.
  - Stage 1 registers the inputs.
  - Stage 2 registers the expanded, blanked, polarity-adjusted outputs.
- Video and measurement outputs hold between strobes.
- Measurement outputs update on the clk_sys edge that samples the qualifying ce_pix, so they are visible the cycle after. frame_width, frame_height, frame_count and meas_valid change together.
- ce_pix held at 0: the whole block freezes, including edge detectors.
- Reset values:
  - colour, vga_de, frame_width, frame_height, frame_count, meas_valid: 0.
  - vga_hs = HS_ACT_LOW, vga_vs = VS_ACT_LOW, i.e. the inactive level.
  - Pipeline and edge-detect registers are cleared.
  - State machine returns to WAIT_VB.
- Reset asserted mid-frame discards partial counts. Measurement restarts from WAIT_VB.

## Structure
- A shared package video_pkg holds:
  - the measurement state enum (WAIT_VB, SYNCED, RUN);
  - the packed RGB field offset constants: R at 0, G at IN_W, B at 2*IN_W.
- One natural sub-module: video_frame_meter, containing the edge detectors, counters and state machine. It is instantiated once.
- Expansion is a generate loop inside the top module.

## Test plan
- Expansion: IN_W=3, OUT_W=8, rgb_i=9'b101_011_110 with blanking low → after 2 ce_pix, vga_r=8'hDB, vga_g=8'h6D, vga_b=8'hB6.
- Blanking and polarity: hblank_i=1, hsync_i=1, default parameters → colour 0 and vga_hs=0 after 2 strobes; with HS_ACT_LOW=0 → vga_hs=1.
- Geometry: ce_pix every 2nd clk, synthetic 256 active × 240 active lines with 3 frames → after the 2nd vblank rise, frame_width=256, frame_height=240, meas_valid=1, frame_count=1; after the 3rd, frame_count=2.
- Saturation and wrap: MEAS_W=4, 20-pixel lines → frame_width=15. 17 frames → frame_count wraps to 0 and meas_valid stays 1.
- Simultaneous events: vblank rises on the strobe where the last active line ends → frame_height includes that line.
- Reset mid-frame: assert reset for 1 cycle during line 100 → all outputs at reset values; meas_valid returns to 1 only after two further vblank rises.
